// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the ACE request arbiter and its clients:
//   - req_type_e  : coherence request type carried on req_type / ace_type
//   - LS_*        : line-state encodings returned on done_state
//   - arb_state_e : arbiter FSM states
//   - final_line_state() : line state reported to the winning requester
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    REQ_READ  = 2'b00,
    REQ_WRITE = 2'b01,
    REQ_INVAL = 2'b10,
    REQ_RSVD  = 2'b11
  } req_type_e;

  localparam logic [2:0] LS_NONE = 3'b000;
  localparam logic [2:0] LS_UC   = 3'b001;
  localparam logic [2:0] LS_SC   = 3'b010;
  localparam logic [2:0] LS_INV  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_e;

  // Invalidates, reserved requests and timed-out transactions always leave
  // the line Invalid; everything else reports what the interconnect returned.
  function automatic logic [2:0] final_line_state(input req_type_e  req_type,
                                                  input logic       timed_out,
                                                  input logic [2:0] resp);
    if (timed_out || (req_type == REQ_INVAL) || (req_type == REQ_RSVD)) begin
      return LS_INV;
    end else begin
      return resp;
    end
  endfunction

endpackage

// File: rtl/ace_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// ace_req_arbiter_if
// Bundles the requester-side and interconnect-side signals of ace_req_arbiter.
//   Requester side : req_valid, req_type, req_addr  -> arbiter
//                    req_ready, done, done_state, done_err <- arbiter
//   ACE side       : ace_valid, ace_type, ace_addr <- arbiter
//                    ace_accept, ace_ready, ace_resp_state -> arbiter
// Modports:
//   master : the arbiter itself
//   slave  : the environment (cache controllers + interconnect)
// -----------------------------------------------------------------------------
interface ace_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_type;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        done;
  logic [2:0]                done_state;
  logic                      done_err;
  logic                      ace_valid;
  logic [1:0]                ace_type;
  logic [ADDR_W-1:0]         ace_addr;
  logic                      ace_accept;
  logic                      ace_ready;
  logic [2:0]                ace_resp_state;

  modport master (
    input  req_valid, req_type, req_addr, ace_accept, ace_ready, ace_resp_state,
    output req_ready, done, done_state, done_err, ace_valid, ace_type, ace_addr
  );

  modport slave (
    output req_valid, req_type, req_addr, ace_accept, ace_ready, ace_resp_state,
    input  req_ready, done, done_state, done_err, ace_valid, ace_type, ace_addr
  );

endinterface

// File: rtl/ace_req_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set req_valid bit searching upward
// from ptr with wrap-around.
// Ports:
//   req_valid [NUM_REQ] in  : request vector
//   ptr       [IDX_W]   in  : highest-priority index this cycle
//   grant     [NUM_REQ] out : one-hot winner (all zero when nothing valid)
//   grant_idx [IDX_W]   out : binary index of the winner
//   any_valid           out : at least one request is valid
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  int cand_s;

  // Walk candidates ptr, ptr+1, ... (mod NUM_REQ); the first valid one wins.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = {IDX_W{1'b0}};
    grant     = {NUM_REQ{1'b0}};
    cand_s    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && req_valid[IDX_W'(cand_s)]) begin
        any_valid = 1'b1;
        grant_idx = IDX_W'(cand_s);
      end else begin
        any_valid = any_valid;
      end
    end
    grant[grant_idx] = any_valid;
  end

endmodule

// File: rtl/ace_req_arbiter.sv
// -----------------------------------------------------------------------------
// ace_req_arbiter
// Shares one ACE request/response channel between NUM_REQ cache controllers.
// A round-robin winner is granted in IDLE, its request is issued on the ACE
// side (ISSUE), the response is awaited (WAIT) and the resulting line state
// is returned with a one-cycle done pulse (DONE). One transaction at a time.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; abandons any transaction silently
//   bus   : ace_req_arbiter_if.master (requester + ACE handshakes)
//   busy  : FSM is not in IDLE
// Optional feature macro: ACE_TIMEOUT_EN -- WAIT watchdog of TIMEOUT_CYC
// cycles; on expiry the transaction completes Invalid with done_err set.
// Without it, WAIT lasts until ace_ready and done_err is constant 0.
// -----------------------------------------------------------------------------
module ace_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  ace_req_arbiter_if.master bus,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Unsupported configurations leave a visible marker in the hierarchy.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYC < 2)) begin : g_bad_config
    logic unsupported_config;
    assign unsupported_config = 1'b1;
  end

  arb_state_e         state_r;
  arb_state_e         state_n;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   win_r;
  req_type_e          type_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [2:0]         resp_r;
  logic               err_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               any_valid_s;
  logic               grant_fire_s;
  logic [1:0]         sel_type_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic               resp_cap_s;

`ifdef ACE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0]   cnt_r;
  logic               timeout_s;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid (bus.req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_valid_s)
  );

  assign grant_fire_s = (state_r == ST_IDLE) && any_valid_s;

  // Mux out the winner's type/address with the one-hot grant as a mask, so
  // non-granted lanes never reach the capture registers.
  always_comb begin
    sel_type_s = 2'b00;
    sel_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_type_s = sel_type_s | (bus.req_type[2*i +: 2] & {2{grant_s[i]}});
      sel_addr_s = sel_addr_s | (bus.req_addr[ADDR_W*i +: ADDR_W] & {ADDR_W{grant_s[i]}});
    end
  end

  // Next-state logic and response-capture strobes.
  always_comb begin
    state_n    = state_r;
    resp_cap_s = 1'b0;
`ifdef ACE_TIMEOUT_EN
    timeout_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_n = (sel_type_s == REQ_RSVD) ? ST_DONE : ST_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // ace_ready is only meaningful once the request has been accepted.
        if (bus.ace_accept && bus.ace_ready) begin
          resp_cap_s = 1'b1;
          state_n    = ST_DONE;
        end else if (bus.ace_accept) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.ace_ready) begin
          resp_cap_s = 1'b1;
          state_n    = ST_DONE;
`ifdef ACE_TIMEOUT_EN
        end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_s = 1'b1;
          state_n   = ST_DONE;
`endif
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register, RR pointer and transaction capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= {IDX_W{1'b0}};
      win_r   <= {IDX_W{1'b0}};
      type_r  <= REQ_READ;
      addr_r  <= {ADDR_W{1'b0}};
      resp_r  <= LS_NONE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      if (grant_fire_s) begin
        win_r  <= grant_idx_s;
        type_r <= req_type_e'(sel_type_s);
        addr_r <= sel_addr_s;
        resp_r <= LS_INV;
        err_r  <= 1'b0;
      end
      if (resp_cap_s) begin
        resp_r <= bus.ace_resp_state;
      end
`ifdef ACE_TIMEOUT_EN
      if (timeout_s) begin
        err_r <= 1'b1;
      end
`endif
      // The pointer only moves on completion, which bounds the wait of a
      // continuously requesting controller to NUM_REQ-1 transactions.
      if (state_r == ST_DONE) begin
        ptr_r <= (win_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (win_r + IDX_W'(1));
      end
    end
  end

`ifdef ACE_TIMEOUT_EN
  // WAIT watchdog: cleared on entry to WAIT, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r != ST_WAIT) && (state_n == ST_WAIT)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`endif

  // Output decode. req_ready is combinational and masked during reset so the
  // reset cycle never shows a grant.
  always_comb begin
    bus.req_ready = ((state_r == ST_IDLE) && !reset) ? grant_s : {NUM_REQ{1'b0}};
    bus.done      = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.done[i] = (state_r == ST_DONE) && (win_r == IDX_W'(i));
    end
    bus.done_state = (state_r == ST_DONE) ? final_line_state(type_r, err_r, resp_r) : LS_NONE;
`ifdef ACE_TIMEOUT_EN
    bus.done_err   = (state_r == ST_DONE) && err_r;
`else
    bus.done_err   = 1'b0;
`endif
    bus.ace_valid  = (state_r == ST_ISSUE);
    bus.ace_type   = type_r;
    bus.ace_addr   = addr_r;
    busy           = (state_r != ST_IDLE);
  end

endmodule
